// File: rtl/comp_pkg.sv
// Shared types and result encoding for the sequential N-bit comparator.
package comp_pkg;

    // Controller states: waiting for a request, or walking bits MSB first.
    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    // Result vector ordering is {g, e, l}; exactly one bit set once decided.
    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_G    = 3'b100;
    localparam res_t RES_E    = 3'b010;
    localparam res_t RES_L    = 3'b001;

endpackage

// File: rtl/comp_nbit_seq_if.sv
// Request/result bundle between a requester and the sequential comparator.
interface comp_nbit_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             l;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, g, e, l
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, g, e, l
    );
endinterface

// File: rtl/comp_bit_cell.sv
// Single-bit magnitude cell; inv flips the sense for a two's complement sign bit.
module comp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic inv,
    output logic gt,
    output logic eq,
    output logic lt
);
    // On a sign bit a set bit means negative, so the larger operand is the one with a 0.
    assign eq = a_bit ~^ b_bit;
    assign gt = ~eq & (a_bit ^ inv);
    assign lt = ~eq & ~(a_bit ^ inv);
endmodule

// File: rtl/comp_nbit_seq.sv
// Bit-serial comparator: scans latched operands MSB first, stops at the first difference.
module comp_nbit_seq
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    comp_nbit_seq_if.slave bus
);
    localparam int unsigned       IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sm_q, sm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    res_t               res_q, res_d;
    logic               done_q, done_d;

    logic cell_gt, cell_eq, cell_lt;

    // Only the bit pair under the index is examined; the sign flip applies to the MSB only.
    comp_bit_cell u_cell (
        .a_bit (a_q[idx_q]),
        .b_bit (b_q[idx_q]),
        .inv   (sm_q & (idx_q == IDX_MAX)),
        .gt    (cell_gt),
        .eq    (cell_eq),
        .lt    (cell_lt)
    );

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= IDX_MAX;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    // Next-state: accept in IDLE, one bit pair per cycle in CMP, decide on first difference.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        idx_d   = idx_q;
        res_d   = res_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sm_d    = bus.signed_mode;
                    idx_d   = IDX_MAX;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!cell_eq) begin
                    res_d   = cell_gt ? RES_G : (cell_lt ? RES_L : RES_NONE);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    res_d   = RES_E;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == CMP);
    assign bus.done = done_q;
    assign bus.g    = res_q[2];
    assign bus.e    = res_q[1];
    assign bus.l    = res_q[0];
endmodule

// File: doc/comp_nbit_seq.md
COMP_NBIT_SEQ -- requirements
Module: comp_nbit_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a compare; sampled only when busy=0.
REQ-005 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 signed_mode  input  1  0 = unsigned, 1 = two's complement; captured with the operands.
REQ-008 busy  output  1  compare in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 g  output  1  A > B.
REQ-011 e  output  1  A == B.
REQ-012 l  output  1  A < B.

Function
REQ-013 The block SHALL use a two-state FSM: IDLE and CMP.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch a, b and signed_mode, set bit index to WIDTH-1, enter CMP, and drive busy=1 from E0.
REQ-015 In CMP, each edge SHALL compare one latched bit pair at the current index, MSB first.
REQ-016 If the bits are equal and index>0, the block SHALL decrement the index and stay in CMP.
REQ-017 If the bits differ, the block SHALL decide at that edge (early termination): unsigned, or non-MSB bit: a-bit=1 gives g, else l; signed and index=WIDTH-1: a-bit=1 gives l, else g.
REQ-018 If the bits are equal and index=0, the block SHALL decide e.
REQ-019 At the deciding edge Ek, the block SHALL register exactly one of g/e/l high, pulse done=1 for one cycle, set busy=0, and return to IDLE.
REQ-020 Latency SHALL be k = WIDTH-i cycles from E0 to Ek, where i is the highest differing bit; k = WIDTH when the operands are equal.
REQ-021 g/e/l SHALL hold their value until the next deciding edge, and SHALL remain stable while busy=1.
REQ-022 start while busy=1 SHALL be ignored, and changes on a/b/signed_mode during CMP SHALL NOT affect the result.
REQ-023 start=1 in the done cycle SHALL be accepted, since busy=0; this gives back-to-back operation with no idle gap.
REQ-024 g, e and l SHALL be mutually exclusive at all times.
REQ-025 With WIDTH=1 and signed_mode=1, bit 0 SHALL be treated as the sign bit (1 < 0).

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE and busy=0, done=0, g=0, e=0, l=0, index=WIDTH-1, and clear the latched operands.
REQ-027 Reset asserted mid-compare SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-028 Reset release SHALL take effect at the first rising clk edge with rst_n=1.

Structure
REQ-029 Package comp_pkg SHALL hold the FSM state enum (IDLE, CMP) and the result encoding constants (RES_G, RES_E, RES_L).
REQ-030 Sub-module comp_bit_cell (combinational 1-bit gt/eq/lt, with a sign-invert input) SHALL be instantiated once, on the indexed bit pair.
REQ-031 Index width SHALL be $clog2(WIDTH), minimum 1; no multi-cycle or combinational path SHALL exist from a/b to the outputs.

Verification (WIDTH=8)
REQ-032 Unsigned a=0xA5, b=0xA5 -> done at E8, e=1, g=l=0, busy high for E0..E7.
REQ-033 a=0x80, b=0x7F: unsigned -> done at E1, g=1; signed -> done at E1, l=1.
REQ-034 Unsigned a=0x12, b=0x13 -> done at E8, l=1; a=0xFF, b=0xFE, signed -> done at E8, g=1 (-1 > -2).
REQ-035 Start a=0x10, b=0x20, then start with a=0xFF, b=0x00 at E1 -> second start ignored, done at E3 with l=1; new start in the done cycle -> accepted, busy stays 1.
REQ-036 rst_n low at E4 of an equal-operand compare -> outputs zero immediately, no done pulse; after release, start a=0x01, b=0x00 -> done at E8, g=1.
REQ-037 A random-operand run in both modes SHALL check one-hot g/e/l and latency REQ-020 against a reference model.
